// File: rtl/fabric2_mport.sv
// Master-side port stage for fabric v2: buffers one OCP request, decodes it to a destination port and relays the response.
// Optional response timeout is compiled in when FABRIC2_MPORT_TIMEOUT_EN is defined.
module fabric2_mport #(
   parameter int unsigned PORTNO_WIDTH   = 11,
   parameter logic [31:0] P0_BASE        = 32'h0000_0000,
   parameter logic [31:0] P0_MASK        = 32'hE000_0000,
   parameter logic [31:0] P1_BASE        = 32'h2000_0000,
   parameter logic [31:0] P1_MASK        = 32'hFFFF_F000,
   parameter logic [31:0] P2_BASE        = 32'h2000_1000,
   parameter logic [31:0] P2_MASK        = 32'hFFFF_F000,
   parameter logic [31:0] P3_BASE        = 32'h2000_2000,
   parameter logic [31:0] P3_MASK        = 32'hFFFF_F000,
   parameter logic [31:0] P4_BASE        = 32'h2000_3000,
   parameter logic [31:0] P4_MASK        = 32'hFFFF_F000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             i_MAddr,
   input  logic [2:0]              i_MCmd,
   input  logic [31:0]             i_MData,
   input  logic [3:0]              i_MByteEn,
   output logic                    o_SCmdAccept,
   output logic [31:0]             o_SData,
   output logic [1:0]              o_SResp,
   output logic [31:0]             o_MAddr,
   output logic [2:0]              o_MCmd,
   output logic [31:0]             o_MData,
   output logic [3:0]              o_MByteEn,
   input  logic                    i_SCmdAccept,
   input  logic [31:0]             i_SData,
   input  logic [1:0]              i_SResp,
   output logic                    o_act,
   output logic                    o_done,
   output logic [PORTNO_WIDTH-1:0] o_portno
);

   localparam logic [2:0] CMD_IDLE  = 3'd0;
   localparam logic [1:0] RESP_NULL = 2'd0;
   localparam logic [1:0] RESP_ERR  = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_ERR} state_t;

   state_t                  state_q, state_d;
   logic [31:0]             addr_q, data_q;
   logic [2:0]              cmd_q;
   logic [3:0]              be_q;
   logic [PORTNO_WIDTH-1:0] portno_q, portno_d;
   logic                    first_q;
   logic                    accept, hit, timeout;
   logic [2:0]              hit_idx;

   // Lower port index wins when regions overlap.
   always_comb begin
      hit     = 1'b1;
      hit_idx = 3'd0;
      if      ((i_MAddr & P0_MASK) == P0_BASE) hit_idx = 3'd0;
      else if ((i_MAddr & P1_MASK) == P1_BASE) hit_idx = 3'd1;
      else if ((i_MAddr & P2_MASK) == P2_BASE) hit_idx = 3'd2;
      else if ((i_MAddr & P3_MASK) == P3_BASE) hit_idx = 3'd3;
      else if ((i_MAddr & P4_MASK) == P4_BASE) hit_idx = 3'd4;
      else                                     hit     = 1'b0;
   end

`ifdef FABRIC2_MPORT_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (state_d == ST_REQ && state_q != ST_REQ)
         cnt_q <= '0;
      else if (state_q == ST_REQ || state_q == ST_RESP)
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign timeout = (state_q == ST_REQ || state_q == ST_RESP) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      portno_d = portno_q;
      accept   = 1'b0;
      o_act    = 1'b0;
      o_done   = 1'b0;
      o_MCmd   = CMD_IDLE;
      o_SResp  = RESP_NULL;
      o_SData  = 32'h0;
      case (state_q)
         ST_IDLE: begin
            accept = !rst && (i_MCmd != CMD_IDLE);
            if (accept) begin
               if (hit) begin
                  portno_d = PORTNO_WIDTH'(hit_idx);
                  state_d  = ST_REQ;
               end else begin
                  state_d  = ST_ERR;
               end
            end
         end
         ST_REQ: begin
            o_act = first_q;
            if (i_SCmdAccept && i_SResp != RESP_NULL) begin
               o_MCmd  = cmd_q;
               o_SResp = i_SResp;
               o_SData = i_SData;
               o_done  = 1'b1;
               state_d = ST_IDLE;
            end else if (timeout) begin
               o_SResp = RESP_ERR;
               o_done  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               o_MCmd = cmd_q;
               if (i_SCmdAccept)
                  state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (i_SResp != RESP_NULL) begin
               o_SResp = i_SResp;
               o_SData = i_SData;
               o_done  = 1'b1;
               state_d = ST_IDLE;
            end else if (timeout) begin
               o_SResp = RESP_ERR;
               o_done  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            o_SResp = RESP_ERR;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         portno_q <= '0;
         first_q  <= 1'b0;
         addr_q   <= 32'h0;
         cmd_q    <= CMD_IDLE;
         data_q   <= 32'h0;
         be_q     <= 4'h0;
      end else begin
         state_q  <= state_d;
         portno_q <= portno_d;
         first_q  <= (state_d == ST_REQ) && (state_q != ST_REQ);
         if (accept) begin
            addr_q <= i_MAddr;
            cmd_q  <= i_MCmd;
            data_q <= i_MData;
            be_q   <= i_MByteEn;
         end
      end
   end

   assign o_SCmdAccept = accept;
   assign o_MAddr      = addr_q;
   assign o_MData      = data_q;
   assign o_MByteEn    = be_q;
   assign o_portno     = portno_q;

endmodule

// File: tb/tb_fabric2_mport.sv
// Directed bench for fabric2_mport; responses are checked against a queue of expected results.
module tb_fabric2_mport;

   localparam logic [2:0] RD  = 3'd2;
   localparam logic [2:0] WR  = 3'd1;
   localparam logic [1:0] DVA = 2'd1;
   localparam logic [1:0] ERR = 2'd3;
`ifdef FABRIC2_MPORT_TIMEOUT_EN
   localparam int EXP_ACT  = 7;
   localparam int EXP_DONE = 6;
`else
   localparam int EXP_ACT  = 6;
   localparam int EXP_DONE = 5;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m_addr, m_data, s_data;
   logic [2:0]  m_cmd;
   logic [3:0]  m_be;
   logic        s_acc;
   logic [1:0]  s_resp;

   logic        o_SCmdAccept, o_act, o_done;
   logic [31:0] o_SData, o_MAddr, o_MData;
   logic [1:0]  o_SResp;
   logic [2:0]  o_MCmd;
   logic [3:0]  o_MByteEn;
   logic [10:0] o_portno;

   typedef struct packed {
      logic [1:0]  resp;
      logic [31:0] data;
      logic        done;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   act_cnt = 0;
   int   done_cnt = 0;
   int   k;

   always #5 clk = ~clk;

   fabric2_mport #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .i_MAddr(m_addr), .i_MCmd(m_cmd), .i_MData(m_data), .i_MByteEn(m_be),
      .o_SCmdAccept(o_SCmdAccept), .o_SData(o_SData), .o_SResp(o_SResp),
      .o_MAddr(o_MAddr), .o_MCmd(o_MCmd), .o_MData(o_MData), .o_MByteEn(o_MByteEn),
      .i_SCmdAccept(s_acc), .i_SData(s_data), .i_SResp(s_resp),
      .o_act(o_act), .o_done(o_done), .o_portno(o_portno)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void push(input logic [1:0] r, input logic [31:0] d, input logic dn);
      exp_t e;
      e.resp = r;
      e.data = d;
      e.done = dn;
      sb.push_back(e);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 32'({o_SCmdAccept, o_act, o_done, o_SResp, o_MCmd, o_portno}), 32'h0);
      chk({tag, "_sdata"}, o_SData, 32'h0);
      chk({tag, "_mbuf"}, o_MAddr | o_MData | 32'(o_MByteEn), 32'h0);
   endtask

   // Response monitor: every non-NULL response must match the oldest expectation.
   always @(negedge clk) begin
      if (o_act)  act_cnt++;
      if (o_done) done_cnt++;
      if (o_SResp != 2'd0) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", 32'(o_SResp), 32'h0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_resp", 32'(o_SResp), 32'(mon_e.resp));
            chk("sb_data", o_SData, mon_e.data);
            chk("sb_done", 32'(o_done), 32'(mon_e.done));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; m_addr = '0; m_cmd = '0; m_data = '0; m_be = '0;
      s_acc = 1'b0; s_data = '0; s_resp = '0;
      cyc(); cyc(); smp();
      chk_zero("reset");
      cyc(); rst = 1'b0; smp();
      chk_zero("post_reset");

      // Read to port 0, slave accepts late and responds later
      cyc(); m_cmd = RD; m_addr = 32'h0000_0100; smp();
      chk("t1_accept", 32'(o_SCmdAccept), 32'h1);
      push(DVA, 32'hDEAD_BEEF, 1'b1);
      cyc(); m_cmd = '0; m_addr = '0; smp();
      chk("t1_act", 32'(o_act), 32'h1);
      chk("t1_portno", 32'(o_portno), 32'h0);
      chk("t1_mcmd", 32'(o_MCmd), 32'(RD));
      chk("t1_maddr", o_MAddr, 32'h0000_0100);
      cyc(); smp();
      chk("t1_act_once", 32'(o_act), 32'h0);
      cyc(); s_acc = 1'b1; smp();
      chk("t1_mcmd_held", 32'(o_MCmd), 32'(RD));
      cyc(); s_acc = 1'b0; smp();
      chk("t1_resp_mcmd", 32'(o_MCmd), 32'h0);
      cyc(); smp();
      cyc(); s_resp = DVA; s_data = 32'hDEAD_BEEF; smp();
      chk("t1_no_accept", 32'(o_SCmdAccept), 32'h0);
      cyc(); s_resp = '0; s_data = '0; smp();
      chk("t1_idle_resp", 32'(o_SResp), 32'h0);

      // Write to port 2, accepted and answered in the same cycle
      cyc(); m_cmd = WR; m_addr = 32'h2000_1004; m_data = 32'h1234_5678; m_be = 4'b0011; smp();
      chk("t2_accept", 32'(o_SCmdAccept), 32'h1);
      push(DVA, 32'h0, 1'b1);
      cyc(); m_cmd = '0; m_addr = '0; m_data = '0; m_be = '0; s_acc = 1'b1; s_resp = DVA; smp();
      chk("t2_act", 32'(o_act), 32'h1);
      chk("t2_portno", 32'(o_portno), 32'h2);
      chk("t2_mcmd", 32'(o_MCmd), 32'(WR));
      chk("t2_mdata", o_MData, 32'h1234_5678);
      chk("t2_mbe", 32'(o_MByteEn), 32'h3);

      // Next cycle is IDLE again: unmapped read is taken immediately
      cyc(); s_acc = 1'b0; s_resp = '0; m_cmd = RD; m_addr = 32'h4000_0000; smp();
      chk("t3_accept", 32'(o_SCmdAccept), 32'h1);
      chk("t2_done_clear", 32'(o_done), 32'h0);
      push(ERR, 32'h0, 1'b0);
      cyc(); m_cmd = '0; m_addr = '0; s_data = 32'hCAFE_F00D; smp();
      chk("t3_act", 32'(o_act), 32'h0);
      chk("t3_mcmd", 32'(o_MCmd), 32'h0);
      chk("t3_portno_hold", 32'(o_portno), 32'h2);
      cyc(); s_data = '0; smp();
      chk("t3_after", 32'(o_SResp), 32'h0);

      // Port 1 in flight while master holds a port-3 read
      cyc(); m_cmd = RD; m_addr = 32'h2000_0010; smp();
      chk("t4_accept1", 32'(o_SCmdAccept), 32'h1);
      cyc(); m_addr = 32'h2000_2008; s_acc = 1'b1; smp();
      chk("t4_req_noacc", 32'(o_SCmdAccept), 32'h0);
      chk("t4_act1", 32'(o_act), 32'h1);
      chk("t4_portno1", 32'(o_portno), 32'h1);
      cyc(); s_acc = 1'b0; smp();
      chk("t4_resp_noacc", 32'(o_SCmdAccept), 32'h0);
      chk("t4_buf_held", o_MAddr, 32'h2000_0010);
      cyc(); s_resp = DVA; s_data = 32'h1111_1111; push(DVA, 32'h1111_1111, 1'b1); smp();
      chk("t4_done_noacc", 32'(o_SCmdAccept), 32'h0);
      cyc(); s_resp = '0; s_data = '0; smp();
      chk("t4_accept2", 32'(o_SCmdAccept), 32'h1);
      cyc(); m_cmd = '0; m_addr = '0; s_acc = 1'b1; s_resp = DVA; s_data = 32'h3333_3333;
      push(DVA, 32'h3333_3333, 1'b1); smp();
      chk("t4_act2", 32'(o_act), 32'h1);
      chk("t4_portno3", 32'(o_portno), 32'h3);
      chk("t4_maddr3", o_MAddr, 32'h2000_2008);

      // Reset while waiting in RESP
      cyc(); s_acc = 1'b0; s_resp = '0; s_data = '0; m_cmd = RD; m_addr = 32'h2000_2000; smp();
      chk("t5_accept", 32'(o_SCmdAccept), 32'h1);
      cyc(); m_cmd = '0; m_addr = '0; s_acc = 1'b1; smp();
      cyc(); s_acc = 1'b0; rst = 1'b1; smp();
      cyc(); rst = 1'b0; s_resp = DVA; s_data = 32'h5555_5555; smp();
      chk_zero("t5_reset");
      cyc(); s_resp = '0; s_data = '0; m_cmd = RD; m_addr = 32'h2000_3FFC; smp();
      chk("t5_accept4", 32'(o_SCmdAccept), 32'h1);
      cyc(); m_cmd = '0; m_addr = '0; s_acc = 1'b1; smp();
      chk("t5_act4", 32'(o_act), 32'h1);
      chk("t5_portno4", 32'(o_portno), 32'h4);
      cyc(); s_acc = 1'b0; s_resp = DVA; s_data = 32'h4444_4444; push(DVA, 32'h4444_4444, 1'b1); smp();
      cyc(); s_resp = '0; s_data = '0; smp();
      chk("t5_idle", 32'(o_SResp), 32'h0);

`ifdef FABRIC2_MPORT_TIMEOUT_EN
      // Slave never answers
      cyc(); m_cmd = RD; m_addr = 32'h1000_0000; smp();
      chk("t6_accept", 32'(o_SCmdAccept), 32'h1);
      cyc(); m_cmd = '0; m_addr = '0; push(ERR, 32'h0, 1'b1); k = 0; smp();
      while (o_SResp == 2'd0 && k < 40) begin
         cyc(); k++; smp();
      end
      chk("t6_timeout_cycle", k, 32'd16);
      chk("t6_mcmd", 32'(o_MCmd), 32'h0);
      cyc(); s_acc = 1'b1; s_resp = DVA; s_data = 32'h7777_7777; smp();
      chk("t6_late_resp", 32'(o_SResp), 32'h0);
      chk("t6_late_done", 32'(o_done), 32'h0);
      cyc(); s_acc = 1'b0; s_resp = '0; s_data = '0;
`endif

      cyc(); smp();
      chk("sb_drain", 32'(sb.size()), 32'h0);
      chk("act_count", act_cnt, EXP_ACT);
      chk("done_count", done_cnt, EXP_DONE);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fabric2_mport.md
Name: fabric2_mport

Overview:
- Master-side port stage for system fabric v2; one instance per CPU master (I and D), feeding fabric2 arbitration/control.
- Buffers one OCP request from the master and decodes its address to a destination port number.
- Drives the act/done/portno handshake consumed by the fabric controller and relays the OCP command and response through the switched path.
- Unmapped addresses are answered locally with ERR and never reach the fabric.

Parameters:
PORTNO_WIDTH, 11, width of destination port number
P0_BASE/P0_MASK, 32'h0000_0000/32'hE000_0000, port 0 region (memory); hit = (addr & MASK) == BASE
P1_BASE/P1_MASK, 32'h2000_0000/32'hFFFF_F000, port 1 region
P2_BASE/P2_MASK, 32'h2000_1000/32'hFFFF_F000, port 2 region
P3_BASE/P3_MASK, 32'h2000_2000/32'hFFFF_F000, port 3 region
P4_BASE/P4_MASK, 32'h2000_3000/32'hFFFF_F000, port 4 region
TIMEOUT_CYCLES, 255, response timeout (only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_MAddr  in  32  master address
i_MCmd  in  3  master command (IDLE=0, WR=1, RD=2)
i_MData  in  32  master write data
i_MByteEn  in  4  master byte enables
o_SCmdAccept  out  1  command accept to master
o_SData  out  32  read data to master
o_SResp  out  2  response to master (NULL=0, DVA=1, ERR=3)
o_MAddr/o_MCmd/o_MData/o_MByteEn  out  32/3/32/4  buffered command to fabric
i_SCmdAccept  in  1  accept from selected slave
i_SData  in  32  read data from selected slave
i_SResp  in  2  response from selected slave
o_act  out  1  transaction start pulse to controller
o_done  out  1  transaction completion pulse to controller
o_portno  out  PORTNO_WIDTH  decoded destination port

Behaviour:
- Reset: state IDLE. All outputs 0: o_MCmd=IDLE, o_SResp=NULL, o_act, o_done, o_SCmdAccept, o_portno, o_SData. Request buffer cleared. Reset mid-transaction abandons it silently (no done).
- States: IDLE, REQ, RESP, ERR.
- IDLE: o_SCmdAccept = (i_MCmd != IDLE).
  - On accept, latch addr/cmd/data/byteen and decode.
  - Port priority is P0 highest, then P1..P4.
  - Hit: latch o_portno = index, go to REQ. Miss: go to ERR.
- REQ:
  - o_act = 1 on the first REQ cycle only, so act is one cycle after accept.
  - o_M* driven from the buffer.
  - Hold until i_SCmdAccept. If i_SResp != NULL in the same cycle, complete immediately (response path below) and go to IDLE; otherwise go to RESP.
- RESP:
  - o_MCmd = IDLE.
  - On i_SResp != NULL: o_SResp = i_SResp and o_SData = i_SData (combinational pass-through), o_done = 1 for that cycle, go to IDLE.
- ERR: one cycle with o_SResp = ERR and o_SData = 0. No o_act and no o_done. Go to IDLE.
- o_SCmdAccept is 0 outside IDLE. At most one outstanding transaction; a new command is taken only from the cycle after return to IDLE.
- o_portno holds its last value until the next accepted decode.
- o_SResp is NULL in all other cycles. Write responses (DVA) are forwarded like read responses.

Optional Feature:
- Macro: FABRIC2_MPORT_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on REQ entry and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT_CYCLES with no response: o_SResp = ERR, o_done = 1, o_MCmd = IDLE, go to IDLE.
  - A late slave response after timeout is ignored.
- Undefined: no counter; the block waits indefinitely in REQ/RESP.

Test Plan:
- Read 0x0000_0100; slave accepts 2 cycles after act, DVA with 0xDEADBEEF 3 cycles later -> o_portno=0, single o_act, master sees DVA/0xDEADBEEF, o_done coincident, o_SCmdAccept low until return to IDLE.
- Write 0x2000_1004, data 0x1234_5678, byteen 4'b0011; slave accepts and returns DVA same cycle -> o_portno=2, fabric sees buffered data/byteen, o_done in REQ cycle, IDLE next cycle.
- Read 0x4000_0000 (unmapped) -> ERR on the cycle after accept, o_act=0, o_done=0, o_MCmd stays IDLE.
- Back-to-back: master holds RD to port 3 while a port-1 transaction is in RESP -> no accept until IDLE; second o_act 2 cycles after first o_done.
- rst asserted in RESP -> next cycle all outputs 0, state IDLE; a following read to port 4 completes normally.
- With FABRIC2_MPORT_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never responds -> ERR and o_done exactly 16 cycles after REQ entry; a late DVA is not forwarded.
